// File: rtl/bram_burst_arbiter.sv
// Round-robin block-transfer arbiter in front of one single-port BRAM.
// Optional critical-word-first reads: define BRAM_CTRL_CRITICAL_WORD_FIRST_EN.
`default_nettype none

module bram_burst_arbiter #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 16,
  parameter int BLOCK_OFFSET_WIDTH = 5,
  parameter int NUM_CH             = 2,
  parameter int RD_LATENCY         = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                ch_req,
  input  logic [NUM_CH-1:0]                ch_rw,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]                ch_grant,
  output logic                             wdata_take,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [BLOCK_OFFSET_WIDTH-1:0]    rdata_idx,
  output logic                             rdata_valid,
  output logic [NUM_CH-1:0]                ch_done,
  output logic                             ena,
  output logic                             wea,
  output logic [ADDR_WIDTH-1:0]            addra,
  output logic [DATA_WIDTH-1:0]            dina,
  input  logic [DATA_WIDTH-1:0]            douta
);

  localparam int BW   = BLOCK_OFFSET_WIDTH;
  localparam int TW   = ADDR_WIDTH - BW;
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [BW-1:0] LAST_K = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                       state;
  logic [CH_W-1:0]              rr_ptr;
  logic [CH_W-1:0]              owner;
  logic [TW-1:0]                base_tag;
  logic [BW-1:0]                k;
  logic [BW-1:0]                off_k;
  logic [RD_LATENCY:0]          pipe_v;
  logic [RD_LATENCY:0]          pipe_last;
  logic [RD_LATENCY:0][BW-1:0]  pipe_idx;

  logic                         arb_found;
  logic [CH_W-1:0]              arb_sel;
  logic [CH_W-1:0]              cand;
  logic [TW-1:0]                sel_tag;
  logic [DATA_WIDTH-1:0]        owner_wdata;

  // Search starts one past the last winner so a busy channel cannot starve others.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!arb_found && ch_req[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  assign sel_tag     = ch_addr[int'(arb_sel)*ADDR_WIDTH + BW +: TW];
  assign owner_wdata = ch_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign wdata_take  = (state == S_WRITE);

`ifdef BRAM_CTRL_CRITICAL_WORD_FIRST_EN
  logic [BW-1:0] start_off;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_off <= '0;
    end else if (state == S_IDLE && arb_found) begin
      start_off <= ch_addr[int'(arb_sel)*ADDR_WIDTH +: BW];
    end
  end

  // Natural BW-bit wrap keeps the burst inside the block.
  assign off_k = start_off + k;
`else
  logic [NUM_CH*BW-1:0] unused_low_bits;

  always_comb begin
    unused_low_bits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unused_low_bits[i*BW +: BW] = ch_addr[i*ADDR_WIDTH +: BW];
    end
  end

  assign off_k = k;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      base_tag    <= '0;
      k           <= '0;
      pipe_v      <= '0;
      pipe_last   <= '0;
      pipe_idx    <= '0;
      ch_grant    <= '0;
      ch_done     <= '0;
      rdata       <= '0;
      rdata_idx   <= '0;
      rdata_valid <= 1'b0;
      ena         <= 1'b0;
      wea         <= 1'b0;
      addra       <= '0;
      dina        <= '0;
    end else begin
      ch_done <= '0;

      // Read-beat tracker: stage RD_LATENCY lines up with douta for that beat.
      pipe_v[0]    <= (state == S_READ);
      pipe_last[0] <= (state == S_READ) && (k == LAST_K);
      pipe_idx[0]  <= off_k;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_idx[i]  <= pipe_idx[i-1];
      end
      rdata_valid <= pipe_v[RD_LATENCY];
      if (pipe_v[RD_LATENCY]) begin
        rdata     <= douta;
        rdata_idx <= pipe_idx[RD_LATENCY];
      end

      case (state)
        S_IDLE: begin
          ena <= 1'b0;
          wea <= 1'b0;
          if (arb_found) begin
            owner    <= arb_sel;
            rr_ptr   <= arb_sel;
            ch_grant <= NUM_CH'(1) << arb_sel;
            base_tag <= sel_tag;
            k        <= '0;
            state    <= ch_rw[arb_sel] ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          ena   <= 1'b1;
          wea   <= 1'b1;
          addra <= {base_tag, k};
          dina  <= owner_wdata;
          k     <= k + 1'b1;
          if (k == LAST_K) begin
            state   <= S_DONE;
            ch_done <= ch_grant;
          end
        end
        S_READ: begin
          ena   <= 1'b1;
          wea   <= 1'b0;
          addra <= {base_tag, off_k};
          k     <= k + 1'b1;
          if (k == LAST_K) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          ena <= 1'b0;
          if (pipe_v[RD_LATENCY] && pipe_last[RD_LATENCY]) begin
            state   <= S_DONE;
            ch_done <= ch_grant;
          end
        end
        S_DONE: begin
          ena      <= 1'b0;
          wea      <= 1'b0;
          ch_grant <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_burst_arbiter.sv
// Directed bench: two arbiter instances (read latency 1 and 3) with BRAM models.
`default_nettype none

module tb_bram_burst_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  req1, rw1, req3, rw3;
  logic [31:0] addr1, addr3;
  logic [63:0] wd1, wd3;

  logic [1:0]  g1, done1, g3, done3;
  logic        take1, rv1, ena1, wea1, take3, rv3, ena3, wea3;
  logic [31:0] rd1, din1, dout1, rd3, din3, dout3;
  logic [4:0]  ri1, ri3;
  logic [15:0] ad1, ad3;

  bram_burst_arbiter #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ch_req(req1), .ch_rw(rw1), .ch_addr(addr1),
    .ch_wdata(wd1), .ch_grant(g1), .wdata_take(take1), .rdata(rd1),
    .rdata_idx(ri1), .rdata_valid(rv1), .ch_done(done1), .ena(ena1),
    .wea(wea1), .addra(ad1), .dina(din1), .douta(dout1)
  );

  bram_burst_arbiter #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ch_req(req3), .ch_rw(rw3), .ch_addr(addr3),
    .ch_wdata(wd3), .ch_grant(g3), .wdata_take(take3), .rdata(rd3),
    .rdata_idx(ri3), .rdata_valid(rv3), .ch_done(done3), .ena(ena3),
    .wea(wea3), .addra(ad3), .dina(din3), .douta(dout3)
  );

  // BRAM models, initialised to mem[i] = i; latency 1 and 3 respectively.
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic [31:0] p3a, p3b;

  initial begin
    dout1 = '0; dout3 = '0; p3a = '0; p3b = '0;
    for (int i = 0; i < 4096; i++) begin
      mem1[i] = i;
      mem3[i] = i;
    end
    forever begin
      @(posedge clk);
      if (ena1) begin
        if (wea1) mem1[ad1[11:0]] = din1;
        else      dout1 <= mem1[ad1[11:0]];
      end
      if (ena3 && wea3) mem3[ad3[11:0]] = din3;
      if (ena3 && !wea3) p3a <= mem3[ad3[11:0]];
      p3b   <= p3a;
      dout3 <= p3b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input int ch, input logic r, input logic wr,
                       input logic [15:0] a);
    if (w == 1) begin
      req1[ch] = r; rw1[ch] = wr; addr1[ch*16 +: 16] = a;
    end else begin
      req3[ch] = r; rw3[ch] = wr; addr3[ch*16 +: 16] = a;
    end
  endtask

  function automatic logic [1:0] gnt(input int w);
    return (w == 1) ? g1 : g3;
  endfunction

  function automatic logic [4:0] exp_idx(input logic [15:0] a, input int j);
    logic [4:0] t;
`ifdef BRAM_CTRL_CRITICAL_WORD_FIRST_EN
    t = a[4:0] + j[4:0];
`else
    t = j[4:0];
`endif
    return t;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_ctrl", {57'd0, g1, take1, ena1, wea1, rv1, done1}, 64'd0);
    chk("rst_addra", {48'd0, ad1}, 64'd0);
    chk("rst_dina", {32'd0, din1}, 64'd0);
    chk("rst_rdata", {27'd0, ri1, rd1}, 64'd0);
  endtask

  // One block read; checks latency, data/index order, beat count and done pulse.
  task automatic run_read(input int w, input int ch, input logic [15:0] a, input int lat);
    int nv, first, last, nd, donec, j;
    logic [4:0] ei;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (gnt(w) != 2'b00) break;
    end
    chk("rd_grant", {62'd0, gnt(w)}, {62'd0, 2'b01 << ch});
    drive(w, ch, 1'b0, 1'b0, a);
    nv = 0; first = -1; last = -1; nd = 0; donec = -1;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if ((w == 1) ? rv1 : rv3) begin
        if (first < 0) first = c;
        last = c;
        ei = exp_idx(a, nv);
        chk("rd_idx", {59'd0, (w == 1) ? ri1 : ri3}, {59'd0, ei});
        chk("rd_data", {32'd0, (w == 1) ? rd1 : rd3}, {48'd0, a[15:5], ei});
        nv++;
      end
      if (((w == 1) ? done1 : done3) != 2'b00) begin
        chk("rd_done_owner", {62'd0, (w == 1) ? done1 : done3}, {62'd0, 2'b01 << ch});
        nd++;
        donec = c;
      end
    end
    j = lat + 2;
    chk("rd_first_valid", first, j);
    chk("rd_beats", nv, 32);
    chk("rd_contiguous", last - first, 31);
    chk("rd_done_count", nd, 1);
    chk("rd_done_cycle", donec, 32 + lat + 1);
    chk("rd_grant_clear", {62'd0, gnt(w)}, 64'd0);
  endtask

  initial begin
    int ntake, donec, nd, ngr, overlap;
    logic [1:0] prev;
    logic [1:0] seq [3];

    rst_n = 1'b0;
    req1 = '0; rw1 = '0; addr1 = '0; wd1 = '0;
    req3 = '0; rw3 = '0; addr3 = '0; wd3 = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    chk("rst_dut3", {57'd0, g3, take3, ena3, wea3, rv3, done3}, 64'd0);
    rst_n = 1'b1;

    // First read from reset: ch0 at 0x0123.
    drive(1, 0, 1'b1, 1'b0, 16'h0123);
    run_read(1, 0, 16'h0123, 1);

    // Block write on ch1; low address bits ignored.
    drive(1, 1, 1'b1, 1'b1, 16'h0405);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (g1 != 2'b00) break;
    end
    chk("wr_grant", {62'd0, g1}, 64'd2);
    drive(1, 1, 1'b0, 1'b1, 16'h0405);
    ntake = 0; donec = -1;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) @(negedge clk);
      if (take1) begin
        wd1[32 +: 32] = 32'hA000 + ntake;
        ntake++;
      end
      if (done1 != 2'b00) begin
        chk("wr_done_owner", {62'd0, done1}, 64'd2);
        donec = c;
      end
    end
    chk("wr_take_cycles", ntake, 32);
    chk("wr_done_cycle", donec, 32);
    chk("wr_mem_first", {32'd0, mem1[12'h400]}, 64'hA000);
    chk("wr_mem_mid", {32'd0, mem1[12'h410]}, 64'hA010);
    chk("wr_mem_last", {32'd0, mem1[12'h41F]}, 64'hA01F);
    chk("wr_mem_above", {32'd0, mem1[12'h420]}, 64'h420);
    chk("wr_mem_below", {32'd0, mem1[12'h3FF]}, 64'h3FF);
    chk("wr_take_idle", {63'd0, take1}, 64'd0);

    // Both channels requesting continuously: last winner was ch1.
    drive(1, 0, 1'b1, 1'b0, 16'h0000);
    drive(1, 1, 1'b1, 1'b0, 16'h0040);
    ngr = 0; overlap = 0; prev = 2'b00;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if ($countones(g1) > 1) overlap++;
      if (g1 != 2'b00 && prev == 2'b00 && ngr < 3) begin
        seq[ngr] = g1;
        ngr++;
      end
      prev = g1;
    end
    drive(1, 0, 1'b0, 1'b0, 16'h0000);
    drive(1, 1, 1'b0, 1'b0, 16'h0040);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if ($countones(g1) > 1) overlap++;
      if (g1 == 2'b00) break;
    end
    chk("rr_grants", ngr, 3);
    chk("rr_first", {62'd0, seq[0]}, 64'd1);
    chk("rr_second", {62'd0, seq[1]}, 64'd2);
    chk("rr_third", {62'd0, seq[2]}, 64'd1);
    chk("rr_overlap", overlap, 0);
    chk("rr_drained", {62'd0, g1}, 64'd0);

    // Critical-word-first candidate address (in-order when feature is off).
    @(negedge clk);
    drive(1, 1, 1'b1, 1'b0, 16'h003D);
    run_read(1, 1, 16'h003D, 1);

    // Reset during beat 10 of a write aborts it.
    drive(1, 0, 1'b1, 1'b1, 16'h0800);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (g1 != 2'b00) break;
    end
    chk("ab_grant", {62'd0, g1}, 64'd1);
    ntake = 0; nd = 0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      if (done1 != 2'b00) nd++;
      if (take1) begin
        wd1[0 +: 32] = 32'hB000 + ntake;
        ntake++;
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    chk("ab_no_done_before", nd, 0);
    chk("ab_takes_before", ntake, 11);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ab_rearbitrate", {62'd0, g1}, 64'd1);
    drive(1, 0, 1'b0, 1'b1, 16'h0800);
    nd = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (take1) wd1[0 +: 32] = 32'hC000;
      if (done1 != 2'b00) nd++;
    end
    chk("ab_second_done", nd, 1);

    // Latency-3 instance.
    drive(3, 0, 1'b1, 1'b0, 16'h0050);
    run_read(3, 0, 16'h0050, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
